alarm_controller: RTL and testbench
===================================

# alarm_controller

Reads the running BCD time digits produced by the clock core, compares them against a programmed alarm time, and drives the buzzer with a square-wave tone. It implements ring timeout, debounced snooze, and a snooze limit. It is the consumer of the clock core's time output and the sole driver of BUZZER.

## Interface

**Parameters**
- TONE_DIV, 25000: clock cycles per BUZZER half-period (1 kHz at 50 MHz).
- DEBOUNCE_CYCLES, 1000000: cycles SNOOZE_KEY must be stable to be accepted (20 ms).
- RING_SECONDS, 60: seconds of ringing before auto-dismiss.
- SNOOZE_MINUTES, 5: snooze duration in minutes.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; the next press dismisses.

**Ports**
- CLOCK_50, in, 1: system clock. Single clock domain.
- RESET, in, 1: asynchronous, active-high reset.
- ALARM_EN, in, 1: alarm armed when high.
- SNOOZE_KEY, in, 1: active-low pushbutton, asynchronous, raw (undebounced).
- HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE, in, 4 each: current time in BCD.
- A_HOUR, in, 8: alarm hour as packed BCD {tens[7:4], ones[3:0]}.
- A_MIN, in, 8: alarm minute as packed BCD {tens[7:4], ones[3:0]}.
- BUZZER, out, 1: tone output.
- RINGING, out, 1: high in RING state.
- SNOOZED, out, 1: high in SNOOZE state.

## Operation

- Reset values: state IDLE; BUZZER, RINGING, SNOOZED = 0; all counters 0; sec_prev = 0; match_d = 0; debounced key = 1 (released).
- **match** is combinational and true when all of the following hold:
  - {HOUR_TEN, HOUR_ONE} == A_HOUR
  - {MIN_TEN, MIN_ONE} == A_MIN
  - SEC_TEN == 0 and SEC_ONE == 0
- match_d registers match. match_rise = match & ~match_d.
- sec_tick is asserted when SEC_ONE != sec_prev. sec_prev registers SEC_ONE every cycle. A spurious tick on the first cycle after reset is harmless because it is ignored in IDLE.
- Key path:
  - 2-flop synchronizer.
  - Stability counter: the debounced value updates after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - press = debounced 1→0 transition, one-cycle pulse.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE → RING on match_rise & ALARM_EN. Clears ring_cnt, snooze_num, tone_cnt.
  - RING → IDLE when ring_cnt reaches RING_SECONDS. ring_cnt increments on sec_tick.
  - RING → IDLE on press when snooze_num == MAX_SNOOZE.
  - RING → SNOOZE on press when snooze_num < MAX_SNOOZE. Increments snooze_num and clears snz_cnt.
  - SNOOZE → RING when snz_cnt reaches SNOOZE_MINUTES*60. snz_cnt increments on sec_tick. Clears ring_cnt and tone_cnt.
  - SNOOZE → RING immediately on match_rise & ALARM_EN, for example after the time is re-set. Clears ring_cnt, tone_cnt and snooze_num.
  - Any state → IDLE when ALARM_EN is low. This takes priority over all other transitions.
  - press in IDLE or SNOOZE is ignored. match_rise in RING is ignored.
- Simultaneous events in RING: press and ring timeout on the same cycle resolve to the press action.
- Tone: in RING, tone_cnt counts 0..TONE_DIV-1 and BUZZER toggles on wrap. BUZZER is forced 0 outside RING and is 0 on RING entry.
- Counter widths: ring_cnt and snz_cnt are sized from the parameters (≥ clog2(SNOOZE_MINUTES*60+1)). tone_cnt ≥ clog2(TONE_DIV). snooze_num ≥ clog2(MAX_SNOOZE+1).
- Invalid BCD input digits (>9) simply never match. No error is flagged.

## Timing

- RING entry: RINGING goes high at the first CLOCK_50 edge at which match is true and match_d is 0, i.e. 1 cycle after the digits present.
- BUZZER first rises TONE_DIV cycles after RING entry. Period is 2*TONE_DIV cycles.
- Snooze latency from a stable key press to SNOOZED = 1: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle.
- ALARM_EN low → IDLE, with outputs 0, on the next edge.
- RESET is asynchronous. Assertion mid-RING drops BUZZER and RINGING immediately, without waiting for a clock.
- Ring timeout: exit on the edge where the RING_SECONDS-th sec_tick is counted.

## Test plan

Sim parameters: TONE_DIV=4, DEBOUNCE_CYCLES=8, RING_SECONDS=3, SNOOZE_MINUTES=1, MAX_SNOOZE=2.

1. Alarm 06:30, ALARM_EN=1, time steps 06:29:59 → 06:30:00 → RINGING=1 one cycle later. BUZZER low for 4 cycles, then toggles every 4 cycles.
2. Ringing, advance SEC_ONE 0→1→2→3 → RINGING=0 and BUZZER=0 after the 3rd tick.
3. Ringing, hold SNOOZE_KEY low 12 cycles → SNOOZED=1 at cycle 2+8+1 and BUZZER=0. After 60 sec_ticks → RINGING=1.
4. Snooze twice, then press a third time → IDLE with RINGING=0 and SNOOZED=0. A glitch of SNOOZE_KEY low for 5 cycles is ignored.
5. Ringing, drop ALARM_EN → all outputs 0 next edge. Raise ALARM_EN at the same matching time → no re-ring (match_d is already 1).
6. Assert RESET mid-RING → BUZZER=0 and RINGING=0 asynchronously. Release during a match at 06:30:00 → RINGING=1 one cycle after release.

Source files
------------

// File: rtl/alarm_controller_if.sv
// Signal bundle between the clock core / front panel and the alarm controller.
// The master side supplies time, alarm setting and key; the slave side drives the buzzer and status.
interface alarm_controller_if;
  logic       ALARM_EN;
  logic       SNOOZE_KEY;
  logic [3:0] HOUR_TEN;
  logic [3:0] HOUR_ONE;
  logic [3:0] MIN_TEN;
  logic [3:0] MIN_ONE;
  logic [3:0] SEC_TEN;
  logic [3:0] SEC_ONE;
  logic [7:0] A_HOUR;
  logic [7:0] A_MIN;
  logic       BUZZER;
  logic       RINGING;
  logic       SNOOZED;

  modport master (
    output ALARM_EN, SNOOZE_KEY,
    output HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE,
    output A_HOUR, A_MIN,
    input  BUZZER, RINGING, SNOOZED
  );

  modport slave (
    input  ALARM_EN, SNOOZE_KEY,
    input  HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE,
    input  A_HOUR, A_MIN,
    output BUZZER, RINGING, SNOOZED
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: matches BCD time against the alarm setting, rings a square-wave buzzer,
// and handles ring timeout, debounced snooze and the per-event snooze limit.
module alarm_controller #(
  parameter int unsigned TONE_DIV        = 25000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RING_SECONDS    = 60,
  parameter int unsigned SNOOZE_MINUTES  = 5,
  parameter int unsigned MAX_SNOOZE      = 3
) (
  input logic               CLOCK_50,
  input logic               RESET,
  alarm_controller_if.slave bus
);

  localparam int unsigned SNZ_SECS = SNOOZE_MINUTES * 60;
  localparam int unsigned CNT_MAX  = (SNZ_SECS > RING_SECONDS) ? SNZ_SECS : RING_SECONDS;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SN_W     = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t state, state_n;

  logic              match, match_d, match_rise, sec_tick;
  logic [3:0]        sec_prev;
  logic              key_s1, key_s2, key_db, key_db_d, press;
  logic [DB_W-1:0]   db_cnt;
  logic [CNT_W-1:0]  ring_cnt, ring_cnt_n, snz_cnt, snz_cnt_n;
  logic [TONE_W-1:0] tone_cnt, tone_cnt_n;
  logic [SN_W-1:0]   snooze_num, snooze_num_n;
  logic              tone_wrap;
  logic              buzzer, buzzer_n, ringing, snoozed;

  assign match = ({bus.HOUR_TEN, bus.HOUR_ONE} == bus.A_HOUR) &&
                 ({bus.MIN_TEN, bus.MIN_ONE} == bus.A_MIN) &&
                 (bus.SEC_TEN == 4'd0) && (bus.SEC_ONE == 4'd0);
  assign match_rise = match & ~match_d;
  assign sec_tick   = (bus.SEC_ONE != sec_prev);
  assign press      = key_db_d & ~key_db;
  assign tone_wrap  = (tone_cnt == TONE_W'(TONE_DIV - 1));

  // Key synchronizer and stability filter; idle level is 1 (released).
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_s1   <= bus.SNOOZE_KEY;
      key_s2   <= key_s1;
      key_db_d <= key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Next-state and counter updates; ALARM_EN low overrides everything.
  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    snz_cnt_n    = snz_cnt;
    tone_cnt_n   = tone_cnt;
    snooze_num_n = snooze_num;
    buzzer_n     = 1'b0;

    if (!bus.ALARM_EN) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match_rise) begin
            state_n      = RING;
            ring_cnt_n   = '0;
            snooze_num_n = '0;
            tone_cnt_n   = '0;
          end
        end
        RING: begin
          // A press wins over a timeout landing on the same cycle.
          if (press) begin
            if (snooze_num == SN_W'(MAX_SNOOZE)) begin
              state_n = IDLE;
            end else begin
              state_n      = SNOOZE;
              snooze_num_n = snooze_num + SN_W'(1);
              snz_cnt_n    = '0;
            end
          end else if (sec_tick && (ring_cnt == CNT_W'(RING_SECONDS - 1))) begin
            state_n = IDLE;
          end else begin
            if (sec_tick) ring_cnt_n = ring_cnt + CNT_W'(1);
            tone_cnt_n = tone_wrap ? '0 : tone_cnt + TONE_W'(1);
            buzzer_n   = buzzer ^ tone_wrap;
          end
        end
        SNOOZE: begin
          if (match_rise) begin
            state_n      = RING;
            ring_cnt_n   = '0;
            tone_cnt_n   = '0;
            snooze_num_n = '0;
          end else if (sec_tick) begin
            if (snz_cnt == CNT_W'(SNZ_SECS - 1)) begin
              state_n    = RING;
              ring_cnt_n = '0;
              tone_cnt_n = '0;
            end else begin
              snz_cnt_n = snz_cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      tone_cnt   <= '0;
      snooze_num <= '0;
      match_d    <= 1'b0;
      sec_prev   <= 4'd0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snz_cnt    <= snz_cnt_n;
      tone_cnt   <= tone_cnt_n;
      snooze_num <= snooze_num_n;
      match_d    <= match;
      sec_prev   <= bus.SEC_ONE;
      buzzer     <= buzzer_n;
      ringing    <= (state_n == RING);
      snoozed    <= (state_n == SNOOZE);
    end
  end

  assign bus.BUZZER  = buzzer;
  assign bus.RINGING = ringing;
  assign bus.SNOOZED = snoozed;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus randomized time/key/enable stimulus,
// every cycle compared against a seconds-and-counts behavioural model.
module tb_alarm_controller;

  localparam int unsigned TONE_DIV        = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;
  localparam int unsigned RING_SECONDS    = 3;
  localparam int unsigned SNOOZE_MINUTES  = 1;
  localparam int unsigned MAX_SNOOZE      = 2;

  localparam int unsigned M_IDLE = 0;
  localparam int unsigned M_RING = 1;
  localparam int unsigned M_SNZ  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_controller_if bus ();

  alarm_controller #(
    .TONE_DIV        (TONE_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RING_SECONDS    (RING_SECONDS),
    .SNOOZE_MINUTES  (SNOOZE_MINUTES),
    .MAX_SNOOZE      (MAX_SNOOZE)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: mode, seconds counted, snoozes used, cycles spent ringing, key history.
  int unsigned m_mode, m_ring_ticks, m_snz_ticks, m_snoozes, m_ring_age, m_run, m_sec_prev;
  bit          m_match_prev, m_s1, m_s2, m_acc, m_acc_prev;
  int unsigned tod;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_match();
    int unsigned ht, ho, mt, mo, st, so, ah, am;
    ht = bus.HOUR_TEN; ho = bus.HOUR_ONE; mt = bus.MIN_TEN; mo = bus.MIN_ONE;
    st = bus.SEC_TEN;  so = bus.SEC_ONE;
    if (ht > 9 || ho > 9 || mt > 9 || mo > 9 || st > 9 || so > 9) return 1'b0;
    ah = 32'(bus.A_HOUR[7:4]) * 10 + 32'(bus.A_HOUR[3:0]);
    am = 32'(bus.A_MIN[7:4]) * 10 + 32'(bus.A_MIN[3:0]);
    return (ht * 10 + ho == ah) && (mt * 10 + mo == am) && (st * 10 + so == 0);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ring_ticks = 0; m_snz_ticks = 0; m_snoozes = 0; m_ring_age = 0;
    m_run = 0; m_sec_prev = 0; m_match_prev = 1'b0;
    m_s1 = 1'b1; m_s2 = 1'b1; m_acc = 1'b1; m_acc_prev = 1'b1;
  endtask

  task automatic start_ring(input bit clear_snoozes);
    m_mode = M_RING; m_ring_ticks = 0; m_ring_age = 0;
    if (clear_snoozes) m_snoozes = 0;
  endtask

  task automatic model_step();
    bit match, rise, tick, press;
    if (rst) begin
      model_reset();
      return;
    end
    match = is_match();
    rise  = match && !m_match_prev;
    tick  = (32'(bus.SEC_ONE) != m_sec_prev);
    press = m_acc_prev && !m_acc;
    if (!bus.ALARM_EN) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (rise) start_ring(1'b1);
    end else if (m_mode == M_RING) begin
      if (press) begin
        if (m_snoozes == MAX_SNOOZE) m_mode = M_IDLE;
        else begin m_snoozes++; m_mode = M_SNZ; m_snz_ticks = 0; end
      end else begin
        if (tick) m_ring_ticks++;
        if (m_ring_ticks == RING_SECONDS) m_mode = M_IDLE;
        else m_ring_age++;
      end
    end else begin
      if (rise) start_ring(1'b1);
      else if (tick) begin
        m_snz_ticks++;
        if (m_snz_ticks == SNOOZE_MINUTES * 60) start_ring(1'b0);
      end
    end
    // Key: two-cycle delay, then accept a level held for DEBOUNCE_CYCLES samples.
    m_acc_prev = m_acc;
    if (m_s2 != m_acc) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin m_acc = m_s2; m_run = 0; end
    end else m_run = 0;
    m_s2 = m_s1;
    m_s1 = bus.SNOOZE_KEY;
    m_match_prev = match;
    m_sec_prev   = 32'(bus.SEC_ONE);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_eq({ph, ".ringing"}, 32'(bus.RINGING), 32'(m_mode == M_RING));
    check_eq({ph, ".snoozed"}, 32'(bus.SNOOZED), 32'(m_mode == M_SNZ));
    check_eq({ph, ".buzzer"}, 32'(bus.BUZZER),
             (m_mode == M_RING) ? ((m_ring_age / TONE_DIV) % 2) : 32'd0);
    @(negedge clk);
  endtask

  task automatic set_time(input int unsigned t);
    int unsigned h, m, s;
    tod = t % 86400;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    bus.HOUR_TEN = 4'(h / 10); bus.HOUR_ONE = 4'(h % 10);
    bus.MIN_TEN  = 4'(m / 10); bus.MIN_ONE  = 4'(m % 10);
    bus.SEC_TEN  = 4'(s / 10); bus.SEC_ONE  = 4'(s % 10);
  endtask

  task automatic set_alarm(input int unsigned h, input int unsigned m);
    bus.A_HOUR = {4'(h / 10), 4'(h % 10)};
    bus.A_MIN  = {4'(m / 10), 4'(m % 10)};
  endtask

  task automatic ring_at_0630(input string ph);
    set_time(6 * 3600 + 29 * 60 + 59);
    step(ph); step(ph);
    set_time(6 * 3600 + 30 * 60);
    step(ph);
    check_eq({ph, "_entry"}, 32'(bus.RINGING), 32'd1);
  endtask

  task automatic hold_key(input int unsigned n, input string ph);
    bus.SNOOZE_KEY = 1'b0;
    repeat (n) step(ph);
    bus.SNOOZE_KEY = 1'b1;
  endtask

  task automatic pass_seconds(input int unsigned n, input string ph);
    for (int i = 0; i < int'(n); i++) begin
      set_time(tod + 1);
      step(ph);
    end
  endtask

  initial begin
    int unsigned r, rate, key_left, en_left, alarm_sec, sel;
    bit key_lvl;

    rst = 1'b1;
    bus.ALARM_EN = 1'b1;
    bus.SNOOZE_KEY = 1'b1;
    set_alarm(6, 30);
    set_time(6 * 3600 + 29 * 60 + 50);
    model_reset();
    @(negedge clk);
    step("rst"); step("rst");
    check_eq("rst_ringing", 32'(bus.RINGING), 32'd0);
    check_eq("rst_buzzer", 32'(bus.BUZZER), 32'd0);
    rst = 1'b0;

    // Ring entry, then tone starting low and toggling every TONE_DIV cycles.
    ring_at_0630("t1");
    for (int k = 1; k <= 9; k++) begin
      step("t1");
      check_eq($sformatf("t1_buzz_age%0d", k), 32'(bus.BUZZER), 32'((k / 4) % 2));
    end

    // Timeout on the third counted second.
    for (int i = 1; i <= 3; i++) begin
      set_time(tod + 1);
      step("t2");
      if (i < 3) begin
        check_eq("t2_still_ringing", 32'(bus.RINGING), 32'd1);
        step("t2");
      end
    end
    check_eq("t2_timeout_ringing", 32'(bus.RINGING), 32'd0);
    check_eq("t2_timeout_buzzer", 32'(bus.BUZZER), 32'd0);

    // Snooze latency 2+8+1 and return to ringing after one minute of ticks.
    ring_at_0630("t3");
    bus.SNOOZE_KEY = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step("t3");
      if (i == 10) check_eq("t3_not_yet_snoozed", 32'(bus.SNOOZED), 32'd0);
      if (i == 11) begin
        check_eq("t3_snoozed", 32'(bus.SNOOZED), 32'd1);
        check_eq("t3_snooze_buzzer", 32'(bus.BUZZER), 32'd0);
      end
    end
    bus.SNOOZE_KEY = 1'b1;
    repeat (12) step("t3");
    pass_seconds(59, "t3");
    check_eq("t3_snooze_holds", 32'(bus.SNOOZED), 32'd1);
    pass_seconds(1, "t3");
    check_eq("t3_rering", 32'(bus.RINGING), 32'd1);

    // Second snooze, glitch rejection, then the limit press dismisses.
    hold_key(12, "t4");
    check_eq("t4_snooze2", 32'(bus.SNOOZED), 32'd1);
    repeat (12) step("t4");
    pass_seconds(60, "t4");
    check_eq("t4_rering2", 32'(bus.RINGING), 32'd1);
    hold_key(5, "t4");
    repeat (15) step("t4");
    check_eq("t4_glitch_ringing", 32'(bus.RINGING), 32'd1);
    check_eq("t4_glitch_snoozed", 32'(bus.SNOOZED), 32'd0);
    hold_key(12, "t4");
    check_eq("t4_dismiss_ringing", 32'(bus.RINGING), 32'd0);
    check_eq("t4_dismiss_snoozed", 32'(bus.SNOOZED), 32'd0);
    repeat (12) step("t4");

    // Enable drop kills ringing; re-enable at the same matching time does not re-ring.
    ring_at_0630("t5");
    repeat (4) step("t5");
    bus.ALARM_EN = 1'b0;
    step("t5");
    check_eq("t5_en_off_ringing", 32'(bus.RINGING), 32'd0);
    check_eq("t5_en_off_buzzer", 32'(bus.BUZZER), 32'd0);
    bus.ALARM_EN = 1'b1;
    repeat (5) step("t5");
    check_eq("t5_no_rering", 32'(bus.RINGING), 32'd0);

    // Asynchronous reset mid-tone, release while the time still matches.
    ring_at_0630("t6");
    repeat (5) step("t6");
    check_eq("t6_buzzer_high", 32'(bus.BUZZER), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_async_buzzer", 32'(bus.BUZZER), 32'd0);
    check_eq("t6_async_ringing", 32'(bus.RINGING), 32'd0);
    @(negedge clk);
    step("t6"); step("t6");
    rst = 1'b0;
    step("t6");
    check_eq("t6_ring_after_release", 32'(bus.RINGING), 32'd1);

    // Randomized traffic: clock jumps toward alarm times, varying tick rate, key bounce, enable drops.
    rate = 2; key_left = 0; en_left = 0; key_lvl = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: begin set_alarm(6, 30);  alarm_sec = 6 * 3600 + 30 * 60; end
          1: begin set_alarm(0, 0);   alarm_sec = 0; end
          2: begin set_alarm(23, 59); alarm_sec = 23 * 3600 + 59 * 60; end
          default: begin set_alarm(12, 5); alarm_sec = 12 * 3600 + 5 * 60; end
        endcase
        tod  = (alarm_sec + 86400 - $urandom_range(1, 6)) % 86400;
        rate = ($urandom_range(0, 1) == 0) ? 2 : 12;
      end else if (r < 6) begin
        tod = $urandom_range(0, 86399);
      end else if ($urandom_range(1, rate) == 1) begin
        tod = tod + 1;
      end
      set_time(tod);
      if ($urandom_range(0, 199) == 0) bus.MIN_ONE = 4'hA;
      if (key_left == 0) begin
        key_lvl  = !key_lvl;
        key_left = key_lvl ? $urandom_range(5, 60) : $urandom_range(1, 20);
      end
      key_left--;
      bus.SNOOZE_KEY = key_lvl;
      if (en_left > 0) begin
        en_left--;
        bus.ALARM_EN = 1'b0;
      end else begin
        bus.ALARM_EN = 1'b1;
        if ($urandom_range(0, 499) == 0) en_left = $urandom_range(1, 5);
      end
      rst = ($urandom_range(0, 1999) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
